// File: rtl/dp_mem_port_arbiter_if.sv
// dp_mem_port_arbiter_if: requester, response and memory-side signals of one arbitrated memory port
interface dp_mem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_op;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      mem_valid;
  logic                      mem_op;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;
  logic [GW-1:0]             grant_id;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_op, mem_addr, mem_wdata,
           busy, grant_id
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_op, mem_addr, mem_wdata,
           busy, grant_id
  );
endinterface

// File: rtl/dp_mem_port_arbiter.sv
// dp_mem_port_arbiter: round-robin sharing of one DP_MEM port, one transaction in flight, with watchdog abort
module dp_mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rstn,
  dp_mem_port_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  // RESP is the response-pulse cycle; no grant there, giving 3 cycles per transaction
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d, grant_q, grant_d, win, grant_nxt;
  logic                found, timeout;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                op_q, op_d, err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rsp_q, rsp_d, ready;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = GW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end
  assign grant_nxt = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign timeout   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsp_d   = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    ready   = '0;
    case (state_q)
      IDLE: if (found) begin
        ready[win] = 1'b1;
        op_d       = bus.req_op[win];
        addr_d     = bus.req_addr[win*ADDR_W +: ADDR_W];
        wdata_d    = bus.req_wdata[win*DATA_W +: DATA_W];
        grant_d    = win;
        cnt_d      = '0;
        state_d    = BUSY;
      end
      BUSY: if (bus.mem_ready || timeout) begin
        rsp_d[grant_q] = 1'b1;
        err_d          = !bus.mem_ready;
        rdata_d        = (bus.mem_ready && !op_q) ? bus.mem_rdata : '0;
        rr_d           = grant_nxt;
        state_d        = RESP;
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // req_ready is forced low while reset is held so every output reads 0 in reset
  assign bus.req_ready = rstn ? ready : '0;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_valid = state_q == BUSY;
  assign bus.busy      = state_q == BUSY;
  assign bus.mem_op    = op_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_dp_mem_port_arbiter.sv
// tb_dp_mem_port_arbiter: directed vector table plus randomized transactions against a transaction-level model
module tb_dp_mem_port_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  dp_mem_port_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) bus ();
  dp_mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  typedef struct {
    logic [3:0]      vm;
    logic [3:0]      ops;
    logic [3:0][7:0] ad;
    logic [3:0][7:0] wd;
    int              dly;
    int              eg;
    logic [7:0]      erd;
    logic            eerr;
  } vec_t;
  vec_t tbl[17];
  logic [7:0] mem_arr[256];
  logic [7:0] ref_mem[256];
  int pass_cnt = 0;
  int total_cnt = 0;
  int ptr = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic vec_t mk(input logic [3:0] vm, input logic [3:0] ops, input logic [31:0] ad,
                              input logic [31:0] wd, input int dly, input int eg,
                              input logic [7:0] erd, input logic eerr);
    vec_t v;
    v.vm = vm; v.ops = ops; v.ad = ad; v.wd = wd; v.dly = dly; v.eg = eg; v.erd = erd; v.eerr = eerr;
    return v;
  endfunction
  function automatic logic [37:0] all_out();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.mem_valid, bus.mem_op,
            bus.mem_addr, bus.mem_wdata, bus.busy, bus.grant_id};
  endfunction
  // One full transaction: accept cycle, dly stalled cycles (or watchdog), response cycle
  task automatic txn(input string nm, input vec_t v);
    int nv, bad;
    bad = 0;
    nv = (v.dly < TO) ? v.dly + 1 : TO;
    @(negedge clk);
    bus.req_valid = v.vm; bus.req_op = v.ops; bus.req_addr = v.ad; bus.req_wdata = v.wd;
    bus.mem_ready = 1'b1; bus.mem_rdata = 8'hEE;
    #1;
    check({nm, " accept"}, {bus.req_ready, bus.busy, bus.mem_valid}, {4'(1 << v.eg), 2'b00});
    for (int c = 0; c < nv; c++) begin
      @(negedge clk);
      bus.mem_ready = (c == v.dly);
      bus.mem_rdata = bus.mem_op ? 8'($urandom) : mem_arr[bus.mem_addr];
      #1;
      if (!(bus.mem_valid && bus.busy && bus.mem_op == v.ops[v.eg] && bus.mem_addr == v.ad[v.eg] &&
            bus.mem_wdata == v.wd[v.eg] && bus.req_ready == 4'b0 && bus.rsp_valid == 4'b0 &&
            int'(bus.grant_id) == v.eg)) bad++;
      if (c == v.dly && bus.mem_op) mem_arr[bus.mem_addr] = bus.mem_wdata;
    end
    check({nm, " busy_cycles_bad"}, 64'(bad), 64'd0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check({nm, " response"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_valid, bus.busy, bus.req_ready},
          {4'(1 << v.eg), v.eerr, v.erd, 2'b00, 4'b0000});
    if (!v.eerr && v.ops[v.eg]) ref_mem[v.ad[v.eg]] = v.wd[v.eg];
    ptr = (v.eg + 1) % 4;
  endtask
  initial begin
    vec_t v;
    int seen;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem_arr[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      mem_arr[8'h40 + i] = 8'hC0 + 8'(i);
      ref_mem[8'h40 + i] = 8'hC0 + 8'(i);
    end
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(4'hF, 4'h0, {8'h43, 8'h42, 8'h41, 8'h40}, '0, 0, i % 4, 8'hC0 + 8'(i % 4), 1'b0);
    tbl[8]  = mk(4'b0100, 4'b0000, {8'h00, 8'h10, 8'h00, 8'h00}, '0, 0, 2, 8'hA5, 1'b0);
    tbl[9]  = mk(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h05}, {24'h0, 8'h3C}, 0, 0, 8'h00, 1'b0);
    tbl[10] = mk(4'b0001, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h05}, '0, 2, 0, 8'h3C, 1'b0);
    tbl[11] = mk(4'b1010, 4'b0010, {8'h77, 8'h00, 8'h77, 8'h00}, {16'h0, 8'h99, 8'h0}, 5, 1, 8'h00, 1'b0);
    tbl[12] = mk(4'b1010, 4'b0000, {8'h77, 8'h00, 8'h77, 8'h00}, '0, TO - 1, 3, 8'h99, 1'b0);
    tbl[13] = mk(4'b1000, 4'b0000, {8'h10, 8'h00, 8'h00, 8'h00}, '0, 99, 3, 8'h00, 1'b1);
    tbl[14] = mk(4'b1001, 4'b0000, {8'h10, 8'h00, 8'h00, 8'h05}, '0, 0, 0, 8'h3C, 1'b0);
    tbl[15] = mk(4'b0011, 4'b0000, {8'h00, 8'h00, 8'h77, 8'h40}, '0, 0, 1, 8'h99, 1'b0);
    tbl[16] = mk(4'b0011, 4'b0000, {8'h00, 8'h00, 8'h77, 8'h40}, '0, 0, 0, 8'hC0, 1'b0);
    bus.req_valid = 4'hF; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'(all_out()), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 17; i++) txn($sformatf("vec%0d", i), tbl[i]);
    for (int n = 0; n < 40; n++) begin
      v.vm = 4'($urandom_range(1, 15));
      v.ops = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        v.ad[k] = 8'($urandom_range(0, 15));
        v.wd[k] = 8'($urandom);
      end
      v.dly = $urandom_range(0, 10);
      v.eg = -1;
      for (int k = 0; k < 4; k++)
        if (v.eg < 0 && v.vm[(ptr + k) % 4]) v.eg = (ptr + k) % 4;
      v.eerr = v.dly >= TO;
      v.erd = (v.eerr || v.ops[v.eg]) ? 8'h00 : ref_mem[v.ad[v.eg]];
      txn($sformatf("rand%0d", n), v);
    end
    @(negedge clk);
    bus.req_valid = 4'b0100; bus.req_op = '0; bus.req_addr = {8'h00, 8'h10, 16'h0}; bus.mem_ready = 1'b0;
    #1;
    check("midop accept", 64'(bus.req_ready), 64'(4'b0100));
    @(negedge clk);
    #1;
    check("midop busy", {bus.mem_valid, bus.busy, bus.grant_id}, {2'b11, 2'd2});
    #2;
    rstn = 1'b0;
    #1;
    check("midop reset_outputs", 64'(all_out()), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (|bus.rsp_valid) seen++;
    end
    check("midop no_rsp_after_reset", 64'(seen), 64'd0);
    ptr = 0;
    txn("after_reset", mk(4'hF, 4'h0, {8'h43, 8'h42, 8'h41, 8'h40}, '0, 0, 0, 8'hC0, 1'b0));
    bus.req_valid = '0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
